add32_scheduler: RTL and testbench

ADD32_SCHEDULER -- requirements
Module: add32_scheduler

---
 rtl/add32_scheduler.sv | 174 +++++++++++++++++
 tb/tb_add32_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add32_scheduler.sv
// add32_scheduler: two-requester 32-bit adder executed as two 16-bit passes over one shared adder.
// Define ADD32_SCHEDULER_RR_EN for round-robin arbitration; default is fixed priority (requester 0 wins).
module add32_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic        req0_cin_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic        req1_cin_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_sum_o,
  output logic        rsp_cout_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic        id_q, id_d;
  logic        lo_carry_q, lo_carry_d;
  logic [15:0] sum_lo_q, sum_lo_d;
  logic        last_id_q, last_id_d;
  logic [31:0] rsp_sum_q, rsp_sum_d;
  logic        rsp_cout_q, rsp_cout_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_valid_q, rsp_valid_d;

  logic        grant0, grant1;
  logic        accept;

  logic [15:0] add_a, add_b;
  logic        add_cin;
  logic [16:0] add_res;

  // Arbitration: a lone valid requester always wins; only contention is resolved by policy.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
`ifdef ADD32_SCHEDULER_RR_EN
      grant0 = last_id_q;
      grant1 = ~last_id_q;
`else
      grant0 = 1'b1;
`endif
    end else begin
      grant0 = req0_valid_i;
      grant1 = req1_valid_i;
    end
  end

  assign req0_ready_o = (state_q == S_IDLE) && grant0;
  assign req1_ready_o = (state_q == S_IDLE) && grant1;
  assign accept       = req0_ready_o || req1_ready_o;

  // The single 16-bit adder: low halves with the request carry, then high halves with the LO carry.
  always_comb begin
    add_a   = a_q[15:0];
    add_b   = b_q[15:0];
    add_cin = cin_q;
    if (state_q == S_HI) begin
      add_a   = a_q[31:16];
      add_b   = b_q[31:16];
      add_cin = lo_carry_q;
    end
  end

  assign add_res = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    id_d        = id_q;
    lo_carry_d  = lo_carry_q;
    sum_lo_d    = sum_lo_q;
    last_id_d   = last_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_LO;
          a_d       = grant1 ? req1_a_i : req0_a_i;
          b_d       = grant1 ? req1_b_i : req0_b_i;
          cin_d     = grant1 ? req1_cin_i : req0_cin_i;
          id_d      = grant1;
          last_id_d = grant1;
        end
      end
      S_LO: begin
        sum_lo_d   = add_res[15:0];
        lo_carry_d = add_res[16];
        state_d    = S_HI;
      end
      S_HI: begin
        rsp_sum_d   = {add_res[15:0], sum_lo_q};
        rsp_cout_d  = add_res[16];
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= 1'b0;
      lo_carry_q  <= 1'b0;
      sum_lo_q    <= '0;
      last_id_q   <= 1'b1;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      lo_carry_q  <= lo_carry_d;
      sum_lo_q    <= sum_lo_d;
      last_id_q   <= last_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_id_o    = rsp_id_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_add32_scheduler.sv
// Scoreboard bench for add32_scheduler: a cycle-level reference model predicts grants and results,
// a separate monitor pops expectations whenever the DUT presents a response.
module tb_add32_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_cin = 1'b0, req1_cin = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, busy;
  logic [31:0] rsp_sum;

  add32_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req0_cin_i   (req0_cin),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .req1_cin_i   (req1_cin),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_sum_o    (rsp_sum),
    .rsp_cout_o   (rsp_cout),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        id;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: the block is free from the cycle after the consumer takes a response;
  // when free, a valid requester is accepted and its result appears 3 cycles after the accept cycle.
  int   m_free_at = 0;
  int   m_resp_from = 0;
  logic m_last_id = 1'b1;

  always @(negedge clk) begin
    bit   idle;
    logic e_r0, e_r1;
    logic [32:0] full;
    exp_t e;
    if (!rst_n) begin
      m_free_at = 0;
      m_last_id = 1'b1;
    end else begin
      idle = (cyc >= m_free_at);
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (idle) begin
        if (req0_valid && req1_valid) begin
`ifdef ADD32_SCHEDULER_RR_EN
          e_r0 = (m_last_id == 1'b1);
          e_r1 = !e_r0;
`else
          e_r0 = 1'b1;
`endif
        end else begin
          e_r0 = req0_valid;
          e_r1 = req1_valid;
        end
      end
      check("busy", busy, !idle);
      check("req0_ready", req0_ready, e_r0);
      check("req1_ready", req1_ready, e_r1);
      if (e_r0 || e_r1) begin
        if (e_r1) full = {1'b0, req1_a} + {1'b0, req1_b} + 33'(req1_cin);
        else      full = {1'b0, req0_a} + {1'b0, req0_b} + 33'(req0_cin);
        e.sum  = full[31:0];
        e.cout = full[32];
        e.id   = e_r1;
        e.due  = cyc + 3;
        exp_q.push_back(e);
        m_last_id   = e_r1;
        m_free_at   = 32'h7fff_ffff;
        m_resp_from = cyc + 3;
      end else if (!idle && cyc >= m_resp_from && rsp_ready) begin
        m_free_at = cyc + 1;
      end
    end
  end

  // Monitor: first cycle of each response pops and compares; held cycles must stay unchanged.
  bit   holding = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 0;
    end else if (rsp_valid) begin
      if (!holding) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected_valid", rsp_valid, 1'b0);
        end else begin
          cur = exp_q.pop_front();
          check("rsp_sum", rsp_sum, cur.sum);
          check("rsp_cout", rsp_cout, cur.cout);
          check("rsp_id", rsp_id, cur.id);
          check("rsp_latency_cycle", cyc, cur.due);
        end
      end else begin
        check("rsp_sum_held", rsp_sum, cur.sum);
        check("rsp_cout_held", rsp_cout, cur.cout);
        check("rsp_id_held", rsp_id, cur.id);
      end
      holding = !rsp_ready;
    end else begin
      if (holding) check("rsp_valid_held", rsp_valid, 1'b1);
      holding = 0;
    end
  end

  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b, input bit cin);
    bit done = 0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) done = 1;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // Scramble the request inputs so an in-flight operation that depends on them is exposed.
    req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom);
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom);
    check("issue_accepted", done, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_sum"}, rsp_sum, 32'd0);
    check({tag, "_rsp_cout"}, rsp_cout, 1'b0);
    check({tag, "_rsp_id"}, rsp_id, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_req0_ready"}, req0_ready, 1'b0);
    check({tag, "_req1_ready"}, req1_ready, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operations, consumer always ready.
    rsp_ready = 1'b1;
    issue(1'b0, 32'h0000FFFF, 32'h00000001, 1'b0);
    idle_cycles(4);
    issue(1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    idle_cycles(4);
    issue(1'b0, 32'hAB1111CD, 32'h11CDAB11, 1'b1);
    idle_cycles(4);

    // Contention at full rate: grant pattern and 4-cycle spacing come from the model.
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle_cycles(5);

    // Backpressure: response held for 5 cycles while both requesters wait.
    rsp_ready = 1'b0;
    issue(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    idle_cycles(2 + 5);
    rsp_ready = 1'b1;
    idle_cycles(3);
    req0_valid = 1'b0; req1_valid = 1'b0;
    idle_cycles(5);

    // Reset during the HI pass aborts the operation.
    issue(1'b1, 32'hDEADBEEF, 32'h01010101, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_in_hi");
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    idle_cycles(6);
    issue(1'b0, 32'h80000000, 32'h80000000, 1'b1);
    idle_cycles(4);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom % 3) == 0;
      req1_valid = ($urandom % 3) == 0;
      req0_a = ($urandom % 8 == 0) ? 32'hFFFFFFFF : $urandom;
      req0_b = $urandom;
      req0_cin = 1'($urandom);
      req1_a = $urandom;
      req1_b = ($urandom % 8 == 0) ? 32'h0000FFFF : $urandom;
      req1_cin = 1'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    idle_cycles(10);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
